// File: rtl/lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lcd_timing_gen
//  Description : LCD raster timing (hsync/vsync/DE) with look-ahead pixel
//                request coordinates and DE-gated RGB forwarding.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int   H_SYNC   = 128,
    parameter int   H_BACK   = 88,
    parameter int   H_DISP   = 800,
    parameter int   H_FRONT  = 40,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_DISP   = 480,
    parameter int   V_FRONT  = 10,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rstn,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_bad_total
        $error("lcd_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1) || (H_DISP < 1) || (V_DISP < 1) || (H_SYNC + H_BACK < 1)) begin : g_bad_width
        $error("lcd_timing_gen: sync, display and sync+back widths must be non-zero");
    end

    // All window bounds are inclusive so nothing needs to represent 2048.
    localparam logic [10:0] c_h_last      = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_v_last      = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_h_sync_last = 11'(H_SYNC - 1);
    localparam logic [10:0] c_v_sync_last = 11'(V_SYNC - 1);
    localparam logic [10:0] c_h_de_first  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] c_h_de_last   = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] c_h_req_first = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_h_req_last  = 11'(H_SYNC + H_BACK + H_DISP - 2);
    localparam logic [10:0] c_v_act_first = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] c_v_act_last  = 11'(V_SYNC + V_BACK + V_DISP - 1);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        first_frame_q;

    logic        w_h_wrap;
    logic        w_vact;
    logic        w_hact;
    logic        w_hreq;

    // The counters hold the position the outputs will show after the next edge.
    always_comb begin
        w_h_wrap = (h_cnt_q == c_h_last);
        h_cnt_d  = w_h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d  = v_cnt_q;
        if (w_h_wrap) begin
            v_cnt_d = (v_cnt_q == c_v_last) ? 11'd0 : v_cnt_q + 11'd1;
        end

        w_vact = (v_cnt_q >= c_v_act_first) && (v_cnt_q <= c_v_act_last);
        w_hact = (h_cnt_q >= c_h_de_first)  && (h_cnt_q <= c_h_de_last);
        w_hreq = (h_cnt_q >= c_h_req_first) && (h_cnt_q <= c_h_req_last);

        hs_d   = (h_cnt_q <= c_h_sync_last) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (v_cnt_q <= c_v_sync_last) ? SYNC_POL : ~SYNC_POL;
        de_d   = w_vact && w_hact;
        xpos_d = (w_vact && w_hreq) ? (h_cnt_q - c_h_req_first) : 11'd0;
        ypos_d = w_vact ? (v_cnt_q - c_v_act_first) : 11'd0;
        fs_d   = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

        frame_cnt_d = frame_cnt_q;
        if (fs_d && !first_frame_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 11'd0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            de_q          <= 1'b0;
            fs_q          <= 1'b0;
            xpos_q        <= 11'd0;
            ypos_q        <= 11'd0;
            frame_cnt_q   <= 8'd0;
            first_frame_q <= 1'b1;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            fs_q          <= fs_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            frame_cnt_q   <= frame_cnt_d;
            first_frame_q <= 1'b0;
        end
    end

    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign lcd_hs      = hs_q;
    assign lcd_vs      = vs_q;
    assign lcd_de      = de_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;
    // Upstream returns data registered one cycle after the request, aligned with DE.
    assign lcd_rgb     = de_q ? pixel_data : 24'h0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_timing_gen
//  Description : Directed bench for lcd_timing_gen, default and small timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_timing_gen;

    localparam int BH = 1056;
    localparam int SH = 22;
    localparam int SF = 154;

    typedef struct {
        int          v;
        int          h;
        logic [63:0] exp;
    } vec_t;

    logic        clk;
    logic        rstn_b, rstn_s;
    logic [23:0] pd_b, pd_s;
    logic [10:0] xpos_b, ypos_b, xpos_s, ypos_s;
    logic        hs_b, vs_b, de_b, fs_b, hs_s, vs_s, de_s, fs_s;
    logic [23:0] rgb_b, rgb_s;
    logic [7:0]  fc_b, fc_s;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_b, cyc_s;
    logic mon_b;

    int hs_cnt_b = 0, vs_cnt_b = 0, de_early_b = 0, de_n_b = 0, de_first_b = -1;
    int rgb_err_b = 0, x_err_b = 0;
    int fs_n_s = 0, fc_step_s = 0, fc_bad_s = 0, de_n_s = 0, de_lines_s = 0, gate_err_s = 0;
    logic [7:0] fc_prev_s = 8'd0;

    lcd_timing_gen u_big (
        .lcd_pclk    (clk),
        .rstn        (rstn_b),
        .pixel_data  (pd_b),
        .pixel_xpos  (xpos_b),
        .pixel_ypos  (ypos_b),
        .lcd_hs      (hs_b),
        .lcd_vs      (vs_b),
        .lcd_de      (de_b),
        .lcd_rgb     (rgb_b),
        .frame_start (fs_b),
        .frame_cnt   (fc_b)
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(16), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4),  .V_FRONT(1)
    ) u_small (
        .lcd_pclk    (clk),
        .rstn        (rstn_s),
        .pixel_data  (pd_s),
        .pixel_xpos  (xpos_s),
        .pixel_ypos  (ypos_s),
        .lcd_hs      (hs_s),
        .lcd_vs      (vs_s),
        .lcd_de      (de_s),
        .lcd_rgb     (rgb_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback pixel source: returns the requested column one cycle later.
    always @(posedge clk) pd_b <= {13'h0, xpos_b};
    assign pd_s = 24'hE0FFFF;

    always @(posedge clk or negedge rstn_b)
        if (!rstn_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
    always @(posedge clk or negedge rstn_s)
        if (!rstn_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;

    // Edge n after release shows hpos=(n-1)%H_TOTAL, vpos=(n-1)/H_TOTAL.
    always @(negedge clk) begin
        if (mon_b && rstn_b && cyc_b > 0 && cyc_b <= 36 * BH) begin
            if ((cyc_b - 1) / BH == 0 && hs_b == 1'b0) hs_cnt_b <= hs_cnt_b + 1;
            if ((cyc_b - 1) / BH <= 2 && vs_b == 1'b0) vs_cnt_b <= vs_cnt_b + 1;
            if ((cyc_b - 1) / BH < 35 && de_b) de_early_b <= de_early_b + 1;
            if ((cyc_b - 1) / BH == 35) begin
                if (de_b) begin
                    if (de_n_b == 0) de_first_b <= (cyc_b - 1) % BH;
                    if (rgb_b != 24'(de_n_b)) rgb_err_b <= rgb_err_b + 1;
                    de_n_b <= de_n_b + 1;
                end
                if (((cyc_b - 1) % BH >= 215) && ((cyc_b - 1) % BH <= 1014)) begin
                    if (int'(xpos_b) != (cyc_b - 1) % BH - 215) x_err_b <= x_err_b + 1;
                end else if (xpos_b != 11'd0) begin
                    x_err_b <= x_err_b + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn_s && cyc_s > 0 && cyc_s <= 1 + SF * 256) begin
            if (fs_s) fs_n_s <= fs_n_s + 1;
            if (cyc_s > 1 && fc_s != fc_prev_s) begin
                if (fs_s) fc_step_s <= fc_step_s + 1;
                else      fc_bad_s  <= fc_bad_s + 1;
            end
            fc_prev_s <= fc_s;
            if (cyc_s <= SF && de_s) begin
                de_n_s <= de_n_s + 1;
                if ((cyc_s - 1) % SH == 4) de_lines_s <= de_lines_s + 1;
            end
            if (cyc_s <= 2 * SF && (de_s ? (rgb_s != 24'hE0FFFF) : (rgb_s != 24'h0)))
                gate_err_s <= gate_err_s + 1;
        end
    end

    function automatic vec_t mk(input int v, h, hs, vs, de, fs, x, y, rgb, cnt);
        vec_t m;
        m.v   = v;
        m.h   = h;
        m.exp = {6'b0, hs[0], vs[0], de[0], fs[0], x[10:0], y[10:0], rgb[23:0], cnt[7:0]};
        return m;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_b(input int n);
        while (cyc_b < n) @(negedge clk);
    endtask

    task automatic wait_s(input int n);
        while (cyc_s < n) @(negedge clk);
    endtask

    task automatic run_big();
        vec_t tab[16];
        //            v    h     hs vs de fs  x    y  rgb  cnt
        tab[0]  = mk( 0,    0,   0, 0, 0, 1,   0, 0,   0, 0);
        tab[1]  = mk( 0,    1,   0, 0, 0, 0,   0, 0,   0, 0);
        tab[2]  = mk( 0,  127,   0, 0, 0, 0,   0, 0,   0, 0);
        tab[3]  = mk( 0,  128,   1, 0, 0, 0,   0, 0,   0, 0);
        tab[4]  = mk( 1, 1055,   1, 0, 0, 0,   0, 0,   0, 0);
        tab[5]  = mk( 2,    0,   0, 1, 0, 0,   0, 0,   0, 0);
        tab[6]  = mk(34,  216,   1, 1, 0, 0,   0, 0,   0, 0);
        tab[7]  = mk(35,  214,   1, 1, 0, 0,   0, 0,   0, 0);
        tab[8]  = mk(35,  215,   1, 1, 0, 0,   0, 0,   0, 0);
        tab[9]  = mk(35,  216,   1, 1, 1, 0,   1, 0,   0, 0);
        tab[10] = mk(35,  217,   1, 1, 1, 0,   2, 0,   1, 0);
        tab[11] = mk(35, 1014,   1, 1, 1, 0, 799, 0, 798, 0);
        tab[12] = mk(35, 1015,   1, 1, 1, 0,   0, 0, 799, 0);
        tab[13] = mk(35, 1016,   1, 1, 0, 0,   0, 0,   0, 0);
        tab[14] = mk(36,    0,   0, 1, 0, 0,   0, 1,   0, 0);
        tab[15] = mk(36,  216,   1, 1, 1, 0,   1, 1,   0, 0);
        for (int i = 0; i < 16; i++) begin
            wait_b(tab[i].v * BH + tab[i].h + 1);
            check($sformatf("big_vec[%0d]", i),
                  {6'b0, hs_b, vs_b, de_b, fs_b, xpos_b, ypos_b, rgb_b, fc_b}, tab[i].exp);
        end

        check("big_hs_cycles_line0",  64'(hs_cnt_b),   64'd128);
        check("big_vs_cycles",        64'(vs_cnt_b),   64'd2112);
        check("big_de_before_vact",   64'(de_early_b), 64'd0);
        check("big_de_cycles_line35", 64'(de_n_b),     64'd800);
        check("big_de_first_hpos",    64'(de_first_b), 64'd216);
        check("big_rgb_loopback",     64'(rgb_err_b),  64'd0);
        check("big_xpos_line35",      64'(x_err_b),    64'd0);

        // Asynchronous reset mid-line at hpos 500, vpos 36.
        wait_b(36 * BH + 500 + 1);
        mon_b = 1'b0;
        #2 rstn_b = 1'b0;
        #1 check("big_async_reset", {6'b0, hs_b, vs_b, de_b, fs_b, xpos_b, ypos_b, rgb_b, fc_b},
                 mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0).exp);
        @(negedge clk);
        rstn_b = 1'b1;
        @(posedge clk);
        #1 check("big_restart_edge", {6'b0, hs_b, vs_b, de_b, fs_b, xpos_b, ypos_b, rgb_b, fc_b},
                 mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0).exp);
    endtask

    task automatic run_small();
        vec_t tab[14];
        //           v   h   hs vs de fs  x   y  rgb        cnt
        tab[0]  = mk(0,  0,  0, 0, 0, 1,  0, 0, 0,         0);
        tab[1]  = mk(0,  1,  0, 0, 0, 0,  0, 0, 0,         0);
        tab[2]  = mk(0,  2,  1, 0, 0, 0,  0, 0, 0,         0);
        tab[3]  = mk(1,  0,  0, 1, 0, 0,  0, 0, 0,         0);
        tab[4]  = mk(1,  4,  1, 1, 0, 0,  0, 0, 0,         0);
        tab[5]  = mk(2,  2,  1, 1, 0, 0,  0, 0, 0,         0);
        tab[6]  = mk(2,  3,  1, 1, 0, 0,  0, 0, 0,         0);
        tab[7]  = mk(2,  4,  1, 1, 1, 0,  1, 0, 'hE0FFFF,  0);
        tab[8]  = mk(2, 18,  1, 1, 1, 0, 15, 0, 'hE0FFFF,  0);
        tab[9]  = mk(2, 19,  1, 1, 1, 0,  0, 0, 'hE0FFFF,  0);
        tab[10] = mk(2, 20,  1, 1, 0, 0,  0, 0, 0,         0);
        tab[11] = mk(5, 10,  1, 1, 1, 0,  7, 3, 'hE0FFFF,  0);
        tab[12] = mk(6, 10,  1, 1, 0, 0,  0, 0, 0,         0);
        tab[13] = mk(7,  0,  0, 0, 0, 1,  0, 0, 0,         1);
        for (int i = 0; i < 14; i++) begin
            wait_s(tab[i].v * SH + tab[i].h + 1);
            check($sformatf("small_vec[%0d]", i),
                  {6'b0, hs_s, vs_s, de_s, fs_s, xpos_s, ypos_s, rgb_s, fc_s}, tab[i].exp);
        end

        wait_s(1 + SF * 255);
        check("small_frame255", {55'b0, fs_s, fc_s}, {55'b0, 1'b1, 8'd255});
        wait_s(SF * 256);
        check("small_before_wrap", {55'b0, fs_s, fc_s}, {55'b0, 1'b0, 8'd255});
        wait_s(1 + SF * 256);
        check("small_wrap_to_0", {55'b0, fs_s, fc_s}, {55'b0, 1'b1, 8'd0});
        wait_s(2 + SF * 256);

        check("small_fs_pulses",   64'(fs_n_s),     64'd257);
        check("small_fc_steps",    64'(fc_step_s),  64'd256);
        check("small_fc_off_fs",   64'(fc_bad_s),   64'd0);
        check("small_de_frame0",   64'(de_n_s),     64'd64);
        check("small_de_lines",    64'(de_lines_s), 64'd4);
        check("small_rgb_gating",  64'(gate_err_s), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2000000 ns, limit 2000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_b = 1'b0;
        rstn_s = 1'b0;
        mon_b  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {6'b0, hs_b, vs_b, de_b, fs_b, xpos_b, ypos_b, rgb_b, fc_b},
              mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0).exp);
        @(negedge clk);
        rstn_b = 1'b1;
        rstn_s = 1'b1;
        fork
            run_big();
            run_small();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Generates LCD panel raster timing: hsync, vsync and data-enable.
- Drives pixel_xpos/pixel_ypos one cycle ahead of data-enable to the pixel-data generator. The generator returns registered pixel_data, and this block forwards it to the panel RGB bus.
- Sits between the panel pins and the display/convolution pixel path, clocked by lcd_pclk.
- Default timing is the 800x480 RGB panel.

Parameters:
- H_SYNC, 128, hsync pulse width in pclk cycles
- H_BACK, 88, horizontal back porch
- H_DISP, 800, active pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high), applies to both hs and vs

Ports:
- lcd_pclk, input, 1, pixel clock (only clock)
- rstn, input, 1, asynchronous active-low reset
- pixel_data, input, 24, RGB888 from pixel generator, registered upstream
- pixel_xpos, output, 11, requested column, valid one cycle before lcd_de
- pixel_ypos, output, 11, current active line index
- lcd_hs, output, 1, horizontal sync
- lcd_vs, output, 1, vertical sync
- lcd_de, output, 1, data enable
- lcd_rgb, output, 24, panel RGB data
- frame_start, output, 1, one-cycle pulse at start of each frame
- frame_cnt, output, 8, frame counter

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (default 1056); V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (default 525).
  - Counter width is 11 bits; both totals must be ≤ 2048, checked at elaboration.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, and wraps to 0 after V_TOTAL-1.
- Output timing: lcd_hs, lcd_vs, lcd_de, pixel_xpos, pixel_ypos and frame_start are registered.
  - Output position (hpos, vpos) is the counter state the registered outputs reflect.
  - On the first lcd_pclk edge after rstn deasserts, outputs show hpos=0, vpos=0.
- lcd_hs is active for hpos in [0, H_SYNC-1], inactive otherwise.
- lcd_vs is active for vpos in [0, V_SYNC-1], over whole lines.
- Vertical active: vact = vpos in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1].
- lcd_de = 1 when vact and hpos in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1]; otherwise 0.
- Request window: req = vact and hpos in [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-2], i.e. one cycle before lcd_de.
  - pixel_xpos = hpos-(H_SYNC+H_BACK-1) when req, else 0.
  - Resulting range is 0..H_DISP-1; xpos=0 appears exactly one cycle before lcd_de rises.
- pixel_ypos = vpos-(V_SYNC+V_BACK) when vact, else 0.
- lcd_rgb = lcd_de ? pixel_data : 24'h0. This is combinational gating of registered signals, with no added latency.
  - pixel_data captured by the upstream stage for column n therefore appears while lcd_de is high for column n.
- frame_start is 1 for exactly the single cycle where hpos=0 and vpos=0.
- frame_cnt increments on the same cycle frame_start is asserted, excluding the first frame after reset, and wraps 255→0.
- Reset (asynchronous, any time including mid-frame):
  - counters clear to 0
  - lcd_hs and lcd_vs go to their inactive level (~SYNC_POL)
  - lcd_de, frame_start, pixel_xpos, pixel_ypos, frame_cnt and lcd_rgb go to 0
  - on release, the raster restarts at hpos=0, vpos=0 and frame_start pulses on the first edge.
- No input handshake: the pixel source must always return data the cycle after the request.

Test Plan:
- Reset/restart: assert rstn=0 mid-line (hpos≈500, vpos≈100).
  - Required immediately, without a clock edge: hs=vs=1, de=0, rgb=0, xpos=ypos=0, frame_cnt=0.
  - Required on release: the next edge gives frame_start=1 and hs=0.
- Horizontal timing, defaults:
  - hs low for 128 cycles per 1056-cycle line.
  - lcd_de high for exactly 800 consecutive cycles starting at hpos 216.
  - No de during vpos 0..34 or 515..524.
- Request alignment:
  - pixel_xpos goes 0 at hpos 215, one cycle before de.
  - pixel_xpos reaches 799 at hpos 1014, the last cycle before de falls.
  - pixel_xpos is 0 elsewhere.
  - pixel_ypos goes 0..479 over vpos 35..514.
- Data pass/gating: loopback pixel_data <= {13'h0, pixel_xpos} registered.
  - Required: lcd_rgb equals 0..799 exactly during de on every active line.
  - Drive pixel_data=24'hE0FFFF constantly → lcd_rgb=0 whenever de=0.
- Vertical timing: vs low for 2 lines (2112 cycles).
  - frame_start pulses every 554400 cycles.
  - 480 active lines per frame.
- Frame counter: run 257 frames → frame_cnt sequence ...254, 255, 0.
  - frame_cnt steps exactly on the frame_start cycles.
- Parameter override: H_DISP=16, H_FRONT=2, H_SYNC=2, H_BACK=2, V_SYNC=1, V_BACK=1, V_DISP=4, V_FRONT=1.
  - Required: line = 22 cycles, frame = 154 cycles, 4 active lines × 16 de cycles.
